cla_subtractor_seq: RTL and testbench
=====================================

// Module: cla_subtractor_seq
// PURPOSE
//   Multi-cycle subtractor: diff = in1 - in2 - borrow_in, built from a SLICE_WID-bit
//   carry-lookahead slice (in1 + ~in2 + ~borrow_in) reused over DATA_WID/SLICE_WID cycles.
//   Inverse-direction companion to the combinational 16-bit CLA adder.
//   Sits behind a valid/ready operand port and in front of a valid/ready result port.
//   Trades latency for area.
// PARAMETERS
//   DATA_WID   16  operand/result width; must be an integer multiple of SLICE_WID
//   SLICE_WID   4  width of the CLA slice evaluated per cycle
//   (derived) NSLICES = DATA_WID/SLICE_WID
// PORTS
//   clk         in   1         rising-edge clock
//   rst_n       in   1         synchronous, active-low reset
//   in_valid    in   1         operands valid
//   in_ready    out  1         block can accept operands
//   in1         in   DATA_WID  minuend
//   in2         in   DATA_WID  subtrahend
//   borrow_in   in   1         borrow into the LSB
//   out_valid   out  1         result valid
//   out_ready   in   1         downstream accepts result
//   diff        out  DATA_WID  in1 - in2 - borrow_in, modulo 2^DATA_WID
//   borrow_out  out  1         1 when the unsigned result is negative (= ~carry out of the MSB slice)
//   overflow    out  1         two's-complement signed overflow
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE; in_ready=1 after reset; out_valid=0.
//     diff, borrow_out, overflow, slice index and internal carry all clear to 0.
//     Reset aborts any in-flight operation; no result is produced for it.
//   - FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&in_ready: latch in1, ~in2 and carry=~borrow_in;
//     set idx=0; go to CALC.
//   - CALC: in_ready=0. Each cycle, slice idx = a[idx] + b[idx] + carry via CLA
//     generate/propagate logic. Write the SLICE_WID-bit sum into diff[idx]; update carry;
//     idx++. After slice NSLICES-1, go to DONE.
//   - DONE: out_valid=1; diff, borrow_out and overflow are held stable.
//     borrow_out = ~final carry.
//     overflow = (in1[MSB]!=in2[MSB]) & (diff[MSB]!=in1[MSB]).
//     On out_ready=1: out_valid drops the next cycle and state returns to IDLE.
//   - Latency: out_valid rises exactly NSLICES cycles after the accept edge.
//     Throughput: at most one operation per NSLICES+2 cycles.
//     in_ready is 0 in DONE, so there is no same-cycle accept on result drain.
//   - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//     Operand changes during CALC/DONE have no effect.
//   - Outputs are registered; diff may be partially updated during CALC and is only
//     meaningful while out_valid=1.
//   - Backpressure: with out_ready=0, the block remains in DONE indefinitely with
//     outputs constant.
// TESTING
//   1 in1=0014 in2=000A bin=0 -> diff=000A borrow_out=0 overflow=0; out_valid 4 cycles after accept
//   2 in1=000A in2=0014 bin=0 -> diff=FFF6 borrow_out=1 overflow=0
//   3 in1=FFFF in2=FFFF bin=1 -> diff=FFFF borrow_out=1 overflow=0;
//     in1=0000 in2=0000 bin=0 -> diff=0000 borrow_out=0
//   4 in1=8000 in2=0001 bin=0 -> diff=7FFF borrow_out=0 overflow=1;
//     in1=7FFF in2=FFFF -> diff=8000 overflow=1 borrow_out=1
//   5 out_ready=0 for 10 cycles in DONE -> out_valid, diff and flags constant, in_ready=0;
//     then out_ready=1 -> IDLE, in_ready=1 next cycle
//   6 rst_n=0 for one cycle mid-CALC -> next cycle in_ready=1, out_valid=0, diff=0;
//     a fresh op then completes correctly

Source files
------------

// File: rtl/cla_subtractor_seq.sv
// cla_subtractor_seq: multi-cycle subtractor reusing one carry-lookahead slice per cycle
// behind valid/ready operand and result ports.
module cla_subtractor_seq #(
    parameter int DATA_WID  = 16,
    parameter int SLICE_WID = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    input  logic                borrow_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WID-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);
    localparam int NSLICES = DATA_WID / SLICE_WID;
    localparam int IW = NSLICES > 1 ? $clog2(NSLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);
    localparam int MSB = DATA_WID - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nx;
    logic [DATA_WID-1:0] a, b;
    logic                carry;
    logic [IW-1:0]       idx;
    logic [SLICE_WID-1:0] sa, sb, g, p, s;
    logic [SLICE_WID:0]  c;

    assign sa        = a[idx*SLICE_WID +: SLICE_WID];
    assign sb        = b[idx*SLICE_WID +: SLICE_WID];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // Each carry is a flat sum of generate terms gated by the propagate run above them.
    always_comb begin
        logic t, pp;
        g = sa & sb;
        p = sa ^ sb;
        c = '0;
        c[0] = carry;
        for (int i = 0; i < SLICE_WID; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & carry);
        end
        s = p ^ c[SLICE_WID-1:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = in_valid ? CALC : IDLE;
            CALC:    state_nx = idx == LAST ? DONE : CALC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a     <= in1;
                b     <= ~in2;
                carry <= ~borrow_in;
                idx   <= '0;
            end else if (state == CALC) begin
                diff[idx*SLICE_WID +: SLICE_WID] <= s;
                carry <= c[SLICE_WID];
                idx   <= idx + IW'(1);
                // b holds ~in2, so equal MSBs here mean the original operand signs differ.
                if (idx == LAST) begin
                    borrow_out <= ~c[SLICE_WID];
                    overflow   <= (a[MSB] == b[MSB]) & (s[SLICE_WID-1] != a[MSB]);
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_subtractor_seq.sv
// tb_cla_subtractor_seq: directed vectors against an arithmetic reference model
// that also predicts handshake timing every cycle.
module tb_cla_subtractor_seq;
    localparam int W  = 16;
    localparam int NS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         borrow_in = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         in_ready, out_valid, borrow_out, overflow;
    logic [W-1:0] diff;

    cla_subtractor_seq #(.DATA_WID(W), .SLICE_WID(NS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .borrow_in(borrow_in), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_bad = 0;
    int           edge_n = 0;
    int           acc_e = 0;
    bit           pend = 0;
    bit           after_rst = 0;
    logic [W-1:0] e_diff = '0;
    logic         e_b = 1'b0;
    logic         e_o = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic predict(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        e_diff = r[W-1:0];
        e_b = r[W];
        e_o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    endtask

    // One clock: update the reference at the edge, compare at the following falling edge.
    task automatic step();
        bit ev;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            pend = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            if (pend && (edge_n - 1 - acc_e) >= NS && out_ready) pend = 0;
            else if (!pend && in_valid) begin
                pend = 1;
                acc_e = edge_n;
                predict(in1, in2, borrow_in);
            end
        end
        @(negedge clk);
        ev = pend && (edge_n - acc_e) >= NS;
        chk("in_ready", 32'(in_ready), 32'(!pend));
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            chk("diff", 32'(diff), 32'(e_diff));
            chk("borrow_out", 32'(borrow_out), 32'(e_b));
            chk("overflow", 32'(overflow), 32'(e_o));
        end
        if (after_rst) begin
            chk("rst_diff", 32'(diff), 32'h0);
            chk("rst_borrow", 32'(borrow_out), 32'h0);
            chk("rst_overflow", 32'(overflow), 32'h0);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                          input logic [W-1:0] ld, input logic lb, input logic lo, input int hold);
        int k;
        in1 = x;
        in2 = y;
        borrow_in = bi;
        in_valid = 1'b1;
        out_ready = hold == 0;
        k = 0;
        while (!pend && k < 20) begin
            step();
            k++;
        end
        in_valid = 1'b0;
        in1 = ~x;
        in2 = ~y;
        borrow_in = ~bi;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: no out_valid for %h-%h-%0d after %0d cycles", x, y, bi, k);
            return;
        end
        chk("latency", 32'(k), 32'(NS));
        chk("lit_diff", 32'(diff), 32'(ld));
        chk("lit_borrow", 32'(borrow_out), 32'(lb));
        chk("lit_overflow", 32'(overflow), 32'(lo));
        repeat (hold) step();
        if (hold > 0) chk("hold_diff", 32'(diff), 32'(ld));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h0014, 16'h000A, 1'b0, 16'h000A, 1'b0, 1'b0, 0);
        run_op(16'h000A, 16'h0014, 1'b0, 16'hFFF6, 1'b1, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
        run_op(16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 0);
        run_op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 10);
        // Abort an operation mid-calculation with a one-cycle reset.
        in1 = 16'h5555;
        in2 = 16'h1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        step();
        run_op(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 0);
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
